instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Upstream stage of the core array. Holds a loadable program RAM of 17-bit core
//  instructions and streams one instruction per clock into the core's instruction_i.
//  A run covers the address range start..end inclusive and repeats it a set number
//  of passes, for example to replay round code. A start/busy/done handshake runs it.
//  The block outputs NOP (all zero: write=0, output_enable=0) whenever it is not streaming.
// PARAMETERS
//  ADDR_W   8   program RAM address width; depth = 2**ADDR_W
//  INSTR_W  17  instruction width; matches the core instruction format
//  REP_W    8   pass-count width
// PORTS
//  clk_i          in   1        clock
//  rst_ni         in   1        reset, asynchronous, active-low
//  prog_we_i      in   1        program RAM write strobe; honoured only in IDLE
//  prog_addr_i    in   ADDR_W   program RAM write address
//  prog_data_i    in   INSTR_W  program RAM write data
//  start_i        in   1        start request; sampled only in IDLE
//  start_addr_i   in   ADDR_W   first address of the range, latched at start
//  end_addr_i     in   ADDR_W   last address of the range, inclusive, latched at start
//  passes_i       in   REP_W    extra passes; total passes = passes_i+1, latched at start
//  abort_i        in   1        synchronous abort of a running program
//  instruction_o  out  INSTR_W  instruction to the core; NOP when valid_o=0
//  valid_o        out  1        instruction_o carries a program instruction
//  busy_o         out  1        sequencer not in IDLE
//  done_o         out  1        1-cycle pulse after the last instruction of the last pass
// BEHAVIOUR
//  Reset: state=IDLE; pc, pass counter and latched range = 0. instruction_o=0,
//   valid_o=0, busy_o=0, done_o=0. RAM contents are not reset.
//  Program RAM has 1-cycle synchronous read and synchronous write.
//   A write in cycle T is visible to a read issued at T+1 or later.
//  FSM states: IDLE -> FETCH -> RUN -> DONE -> IDLE.
//  IDLE: if start_i=1 at edge T, latch the range and passes; pc<=start; go to FETCH.
//  FETCH (T+1): issue the read of pc; busy_o=1; valid_o=0; go to RUN.
//  RUN: valid_o=1 every cycle; instruction_o = prog[pc] registered.
//   The first instruction appears at T+2. pc advances by 1 per cycle, modulo 2**ADDR_W.
//  Pass boundary: when pc reaches end and passes remain, the next read is start.
//   There is no bubble between passes.
//  Length per pass = ((end-start) mod 2**ADDR_W)+1; end<start wraps through 0.
//  After the last instruction of the last pass, go to DONE for one cycle:
//   done_o=1, valid_o=0, instruction_o=0, busy_o=1. Then return to IDLE.
//  Total valid cycles = (passes_i+1)*length, with no gaps in the base build.
//  abort_i=1 in FETCH/RUN/DONE: next cycle state=IDLE, valid_o=0, instruction_o=0.
//   No done_o pulse is produced. abort_i has priority over every other transition.
//  start_i outside IDLE is ignored. prog_we_i outside IDLE is ignored; the RAM is unchanged.
//  start_i and prog_we_i together in IDLE: the write completes and the start is
//   accepted. The first read happens after the write, so it returns the new data.
//  Async reset mid-run: immediate return to reset values. No done_o pulse.
// CONFIGURATION
//  SEQ_STALL_EN defined: adds input stall_i (1 bit).
//   In RUN, while stall_i=1: pc holds, valid_o=0, instruction_o=0.
//   On release, the stream resumes with the instruction that would have come next.
//   No instruction is lost or duplicated; stall latency is absorbed by re-issuing the held read.
//   The pass and done logic are unaffected. stall_i is ignored outside RUN.
//  SEQ_STALL_EN undefined: no stall_i port; RUN streams unconditionally.
// TESTING
//  Load prog[0..3]=17'h00011..17'h00014, start=0, end=3, passes=0
//   -> valid_o for 4 cycles from T+2 with data 11,12,13,14; done_o at T+6; busy_o low at T+7.
//  start=2, end=3, passes=2 -> sequence 13,14,13,14,13,14 with no gaps; exactly one done_o pulse.
//  ADDR_W=8, start=8'hFE, end=8'h01 -> addresses FE,FF,00,01 emitted in that order.
//  abort_i in the third RUN cycle -> valid_o=0 on the next cycle; no done_o; busy_o=0.
//   A new start is then accepted normally.
//  prog_we_i during RUN to an in-range address -> streamed data unchanged;
//   a later read shows the old value. start_i during RUN is ignored.
//  SEQ_STALL_EN: stall_i high for 3 cycles mid-stream -> 3 NOP cycles;
//   the full sequence is still complete and in order.

Source files
------------

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: program RAM plus a start/busy/done sequencer that
// streams one instruction per clock into the core array, looping the address
// range start..end (inclusive, wrapping through 0) for passes+1 passes.
// Optional feature macro: SEQ_STALL_EN adds a stall_i input that pauses the
// stream in RUN without losing or duplicating instructions.
module instruction_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 17,
    parameter int REP_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               prog_we_i,
    input  logic [ADDR_W-1:0]  prog_addr_i,
    input  logic [INSTR_W-1:0] prog_data_i,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  start_addr_i,
    input  logic [ADDR_W-1:0]  end_addr_i,
    input  logic [REP_W-1:0]   passes_i,
    input  logic               abort_i,
`ifdef SEQ_STALL_EN
    input  logic               stall_i,
`endif
    output logic [INSTR_W-1:0] instruction_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W-1:0]  end_addr;
    logic [REP_W-1:0]   pass_left;
    logic               last_issued;

    logic [INSTR_W-1:0] prog_ram [2**ADDR_W];

    logic               stall;
    logic               at_end;
    logic               final_read;
    logic [ADDR_W-1:0]  next_pc;
    logic [REP_W-1:0]   next_pass_left;

`ifdef SEQ_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    // Next read address and pass bookkeeping for the read issued this cycle.
    always_comb begin
        at_end         = (pc == end_addr);
        final_read     = at_end && (pass_left == '0);
        next_pc        = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        next_pass_left = pass_left;
        if (at_end) begin
            next_pc = start_addr;
            if (pass_left != '0) begin
                next_pass_left = pass_left - {{(REP_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Program RAM writes are only accepted while the sequencer is idle.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && (state == IDLE)) begin
            prog_ram[prog_addr_i] <= prog_data_i;
        end
    end

    // Sequencer FSM; the RAM read data register doubles as instruction_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            pc            <= '0;
            start_addr    <= '0;
            end_addr      <= '0;
            pass_left     <= '0;
            last_issued   <= 1'b0;
            instruction_o <= '0;
            valid_o       <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else if (abort_i && (state != IDLE)) begin
            state         <= IDLE;
            last_issued   <= 1'b0;
            instruction_o <= '0;
            valid_o       <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        start_addr  <= start_addr_i;
                        end_addr    <= end_addr_i;
                        pass_left   <= passes_i;
                        pc          <= start_addr_i;
                        last_issued <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    instruction_o <= prog_ram[pc];
                    valid_o       <= 1'b1;
                    pc            <= next_pc;
                    pass_left     <= next_pass_left;
                    last_issued   <= final_read;
                    state         <= RUN;
                end
                RUN: begin
                    if (stall) begin
                        instruction_o <= '0;
                        valid_o       <= 1'b0;
                    end else if (last_issued) begin
                        instruction_o <= '0;
                        valid_o       <= 1'b0;
                        done_o        <= 1'b1;
                        state         <= DONE;
                    end else begin
                        instruction_o <= prog_ram[pc];
                        valid_o       <= 1'b1;
                        pc            <= next_pc;
                        pass_left     <= next_pass_left;
                        last_issued   <= final_read;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed steps with a
// scoreboard queue of expected instructions filled from a bench-side RAM model.
// Define SEQ_STALL_EN for both files to exercise the stall feature.
module tb_instruction_sequencer;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 17;
    localparam int REP_W   = 8;

    logic               clock;
    logic               reset_n;
    logic               prog_we_i;
    logic [ADDR_W-1:0]  prog_addr_i;
    logic [INSTR_W-1:0] prog_data_i;
    logic               start_i;
    logic [ADDR_W-1:0]  start_addr_i;
    logic [ADDR_W-1:0]  end_addr_i;
    logic [REP_W-1:0]   passes_i;
    logic               abort_i;
`ifdef SEQ_STALL_EN
    logic               stall_i;
`endif
    logic [INSTR_W-1:0] instruction_o;
    logic               valid_o;
    logic               busy_o;
    logic               done_o;

    logic [INSTR_W-1:0] model [256];
    logic [INSTR_W-1:0] sbQueue [$];

    int checkCount = 0;
    int errorCount = 0;
    int firstValid;
    int doneIdx;
    int idleIdx;
    int doneCount;
    int validCount;

    instruction_sequencer #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .REP_W  (REP_W)
    ) dut (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .prog_we_i    (prog_we_i),
        .prog_addr_i  (prog_addr_i),
        .prog_data_i  (prog_data_i),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .passes_i     (passes_i),
        .abort_i      (abort_i),
`ifdef SEQ_STALL_EN
        .stall_i      (stall_i),
`endif
        .instruction_o(instruction_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic loadWord(input logic [ADDR_W-1:0] addr, input logic [INSTR_W-1:0] data);
        prog_we_i   = 1'b1;
        prog_addr_i = addr;
        prog_data_i = data;
        nextCycle();
        prog_we_i   = 1'b0;
        model[addr] = data;
    endtask

    task automatic pushExpected(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                                input logic [REP_W-1:0] p);
        logic [ADDR_W-1:0] a;
        for (int pass = 0; pass <= int'(p); pass++) begin
            a = s;
            for (int k = 0; k < 256; k++) begin
                sbQueue.push_back(model[a]);
                if (a == e) break;
                a = a + 8'd1;
            end
        end
    endtask

    // Drives one start request; the bench is then in the FETCH cycle.
    task automatic applyStimulus(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                                 input logic [REP_W-1:0] p);
        pushExpected(s, e, p);
        start_i      = 1'b1;
        start_addr_i = s;
        end_addr_i   = e;
        passes_i     = p;
        nextCycle();
        start_i      = 1'b0;
    endtask

    // Samples each cycle at the falling edge until busy_o drops (bounded).
    task automatic runAndCheck(input string tag, input int total, input int gaps);
        logic [INSTR_W-1:0] exp;
        firstValid = -1;
        doneIdx    = -1;
        idleIdx    = -1;
        doneCount  = 0;
        validCount = 0;
        for (int idx = 0; idx < 600; idx++) begin
            @(negedge clock);
            if (valid_o) begin
                if (firstValid < 0) firstValid = idx;
                validCount++;
                if (sbQueue.size() == 0) begin
                    checkOutput({tag, " extra instruction"}, 32'(instruction_o), 32'hFFFF_FFFF);
                end else begin
                    exp = sbQueue.pop_front();
                    checkOutput({tag, " data"}, 32'(instruction_o), 32'(exp));
                end
            end else begin
                checkOutput({tag, " nop"}, 32'(instruction_o), 32'd0);
            end
            if (done_o) begin
                doneCount++;
                doneIdx = idx;
            end
            if (!busy_o) begin
                idleIdx = idx;
                break;
            end
        end
        checkOutput({tag, " first valid cycle"}, 32'(firstValid), 32'd1);
        checkOutput({tag, " valid count"}, 32'(validCount), 32'(total));
        checkOutput({tag, " done cycle"}, 32'(doneIdx), 32'(1 + total + gaps));
        checkOutput({tag, " idle cycle"}, 32'(idleIdx), 32'(2 + total + gaps));
        checkOutput({tag, " done pulses"}, 32'(doneCount), 32'd1);
        checkOutput({tag, " scoreboard empty"}, 32'(sbQueue.size()), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        int doneSeen;
        reset_n      = 1'b0;
        prog_we_i    = 1'b0;
        prog_addr_i  = '0;
        prog_data_i  = '0;
        start_i      = 1'b0;
        start_addr_i = '0;
        end_addr_i   = '0;
        passes_i     = '0;
        abort_i      = 1'b0;
`ifdef SEQ_STALL_EN
        stall_i      = 1'b0;
`endif
        for (int i = 0; i < 256; i++) model[i] = '0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset instruction", 32'(instruction_o), 32'd0);
        checkOutput("reset valid", 32'(valid_o), 32'd0);
        checkOutput("reset busy", 32'(busy_o), 32'd0);
        checkOutput("reset done", 32'(done_o), 32'd0);
        reset_n = 1'b1;
        nextCycle();

        for (int i = 0; i < 8; i++) loadWord(8'(i), 17'h00011 + 17'(i));
        loadWord(8'hFE, 17'h100FE);
        loadWord(8'hFF, 17'h100FF);

        $display("[TB] basic run 0..3");
        applyStimulus(8'd0, 8'd3, 8'd0);
        runAndCheck("basic", 4, 0);

        $display("[TB] multi-pass run 2..3 x3");
        applyStimulus(8'd2, 8'd3, 8'd2);
        runAndCheck("multipass", 6, 0);

        $display("[TB] wrap run FE..01");
        applyStimulus(8'hFE, 8'h01, 8'd0);
        runAndCheck("wrap", 4, 0);

        $display("[TB] single address, single pass");
        applyStimulus(8'd5, 8'd5, 8'd0);
        runAndCheck("single", 1, 0);

        $display("[TB] abort in third RUN cycle");
        applyStimulus(8'd0, 8'd3, 8'd0);
        sbQueue.delete();
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("abort pre valid", 32'(valid_o), 32'd1);
        checkOutput("abort pre data", 32'(instruction_o), 32'(model[2]));
        abort_i = 1'b1;
        nextCycle();
        abort_i = 1'b0;
        checkOutput("abort valid", 32'(valid_o), 32'd0);
        checkOutput("abort busy", 32'(busy_o), 32'd0);
        checkOutput("abort instruction", 32'(instruction_o), 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done_o) doneSeen++;
        end
        checkOutput("abort no done", 32'(doneSeen), 32'd0);
        applyStimulus(8'd0, 8'd3, 8'd0);
        runAndCheck("after abort", 4, 0);

        $display("[TB] write and start ignored during RUN");
        applyStimulus(8'd0, 8'd3, 8'd0);
        fork
            runAndCheck("busy write", 4, 0);
            begin
                nextCycle();
                prog_we_i    = 1'b1;
                prog_addr_i  = 8'd2;
                prog_data_i  = 17'h1ABCD;
                start_i      = 1'b1;
                start_addr_i = 8'd6;
                end_addr_i   = 8'd7;
                passes_i     = 8'd5;
                nextCycle();
                nextCycle();
                prog_we_i    = 1'b0;
                start_i      = 1'b0;
            end
        join
        applyStimulus(8'd2, 8'd2, 8'd0);
        runAndCheck("old value", 1, 0);

        $display("[TB] write and start in the same IDLE cycle");
        model[6]    = 17'h0BEEF;
        prog_we_i   = 1'b1;
        prog_addr_i = 8'd6;
        prog_data_i = 17'h0BEEF;
        applyStimulus(8'd6, 8'd6, 8'd1);
        prog_we_i   = 1'b0;
        runAndCheck("write+start", 2, 0);

`ifdef SEQ_STALL_EN
        $display("[TB] stall for three cycles mid-stream");
        applyStimulus(8'd0, 8'd3, 8'd1);
        fork
            runAndCheck("stall", 8, 3);
            begin
                nextCycle();
                nextCycle();
                nextCycle();
                stall_i = 1'b1;
                nextCycle();
                nextCycle();
                nextCycle();
                stall_i = 1'b0;
            end
        join
`endif

        $display("[TB] async reset mid-run");
        applyStimulus(8'd0, 8'd7, 8'd3);
        sbQueue.delete();
        nextCycle();
        nextCycle();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrun reset valid", 32'(valid_o), 32'd0);
        checkOutput("midrun reset busy", 32'(busy_o), 32'd0);
        checkOutput("midrun reset instruction", 32'(instruction_o), 32'd0);
        checkOutput("midrun reset done", 32'(done_o), 32'd0);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        applyStimulus(8'd0, 8'd3, 8'd0);
        runAndCheck("after reset", 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
